// File: rtl/key_updown_counter.sv
// Up/down counter driven by three bouncing active-low keys (plus, minus, clear); plus/minus auto-repeat while held.
// Latency: event pulse DEBOUNCE_CYC+2 cycles after the first low sample of a key; count follows one cycle after the pulse.
// Backpressure: none; every event pulse is consumed by the counter in the cycle it is raised.
module key_updown_counter #(
    parameter int CNT_W          = 4,
    parameter int CNT_MAX        = 2**CNT_W - 1,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int REPEAT_DLY_CYC = 25_000_000,
    parameter int REPEAT_PER_CYC = 5_000_000,
    parameter int WRAP           = 1
) (
    input  logic             clk_50mhz,
    input  logic             rst_n,
    input  logic             key_plus,
    input  logic             key_minus,
    input  logic             key_clear,
    output logic [CNT_W-1:0] count,
    output logic             plus_evt,
    output logic             minus_evt,
    output logic             at_max,
    output logic             at_min
);
    // Key index: 0 = plus, 1 = minus, 2 = clear (clear never repeats).
    localparam int KEY_N   = 3;
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int RPT_MAX = (REPEAT_DLY_CYC > REPEAT_PER_CYC) ? REPEAT_DLY_CYC : REPEAT_PER_CYC;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY_CYC - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_FILT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_FILT = 2'd3
    } key_state_t;

    logic [KEY_N-1:0] w_key_raw;
    logic [KEY_N-1:0] w_evt;
    logic [CNT_W-1:0] r_count;

    assign w_key_raw = {key_clear, key_minus, key_plus};

    for (genvar g = 0; g < KEY_N; g++) begin : g_key
        localparam bit RPT_EN = (g != KEY_N - 1);

        logic             r_sync1;
        logic             r_sync2;
        key_state_t       r_state;
        logic [DB_W-1:0]  r_db_cnt;
        logic [RPT_W-1:0] r_rpt_cnt;
        logic             r_rpt_first;
        logic             r_evt;
        logic             w_rpt_hit;

        // First repeat waits the long delay, later ones the short period.
        assign w_rpt_hit = r_rpt_first ? (r_rpt_cnt == DLY_LAST) : (r_rpt_cnt == PER_LAST);

        // Two-flop synchroniser; idles high so reset looks like a released key.
        always_ff @(posedge clk_50mhz or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= w_key_raw[g];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce FSM with registered press/repeat pulse; repeat timer frozen during release filtering.
        always_ff @(posedge clk_50mhz or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= RELEASED;
                r_db_cnt    <= '0;
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b1;
                r_evt       <= 1'b0;
            end else begin
                r_evt <= 1'b0;
                unique case (r_state)
                    RELEASED: begin
                        r_rpt_cnt   <= '0;
                        r_rpt_first <= 1'b1;
                        if (!r_sync2) begin
                            r_state  <= PRESS_FILT;
                            r_db_cnt <= DB_W'(1);
                        end
                    end
                    PRESS_FILT: begin
                        if (r_sync2) begin
                            r_state  <= RELEASED;
                            r_db_cnt <= '0;
                        end else if (r_db_cnt == DB_LAST) begin
                            r_state     <= HELD;
                            r_db_cnt    <= '0;
                            r_rpt_cnt   <= '0;
                            r_rpt_first <= 1'b1;
                            r_evt       <= 1'b1;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_W'(1);
                        end
                    end
                    HELD: begin
                        if (r_sync2) begin
                            r_state  <= RELEASE_FILT;
                            r_db_cnt <= DB_W'(1);
                        end else if (RPT_EN) begin
                            if (w_rpt_hit) begin
                                r_evt       <= 1'b1;
                                r_rpt_cnt   <= '0;
                                r_rpt_first <= 1'b0;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                            end
                        end
                    end
                    RELEASE_FILT: begin
                        if (!r_sync2) begin
                            r_state  <= HELD;
                            r_db_cnt <= '0;
                        end else if (r_db_cnt == DB_LAST) begin
                            r_state     <= RELEASED;
                            r_db_cnt    <= '0;
                            r_rpt_cnt   <= '0;
                            r_rpt_first <= 1'b1;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_W'(1);
                        end
                    end
                    default: r_state <= RELEASED;
                endcase
            end
        end

        assign w_evt[g] = r_evt;
    end

    // Count update: clear wins, simultaneous plus/minus cancel, limits wrap or saturate.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_evt[2]) begin
            r_count <= '0;
        end else if (w_evt[0] && !w_evt[1]) begin
            if (r_count != MAX_VAL) begin
                r_count <= r_count + CNT_W'(1);
            end else if (WRAP != 0) begin
                r_count <= '0;
            end
        end else if (w_evt[1] && !w_evt[0]) begin
            if (r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end else if (WRAP != 0) begin
                r_count <= MAX_VAL;
            end
        end
    end

    assign count     = r_count;
    assign plus_evt  = w_evt[0];
    assign minus_evt = w_evt[1];
    assign at_max    = (r_count == MAX_VAL);
    assign at_min    = (r_count == '0);

endmodule

// File: tb/tb_key_updown_counter.sv
// Bench for key_updown_counter: one wrapping and one saturating instance share the same key waveforms.
// Reference model works on sampled key run lengths and hold-cycle counts, updated once per clock.
// Outputs are compared on every falling edge, plus scenario-level event and count checks.
module tb_key_updown_counter;
    localparam int CW   = 4;
    localparam int CMAX = 9;
    localparam int DB   = 8;
    localparam int RDLY = 32;
    localparam int RPER = 8;

    logic          clk_50mhz = 1'b0;
    logic          rst_n     = 1'b0;
    logic          key_plus  = 1'b1;
    logic          key_minus = 1'b1;
    logic          key_clear = 1'b1;
    logic [CW-1:0] count_w, count_s;
    logic          pe_w, me_w, amax_w, amin_w;
    logic          pe_s, me_s, amax_s, amin_s;

    always #10 clk_50mhz = ~clk_50mhz;

    key_updown_counter #(.CNT_W(CW), .CNT_MAX(CMAX), .DEBOUNCE_CYC(DB),
                         .REPEAT_DLY_CYC(RDLY), .REPEAT_PER_CYC(RPER), .WRAP(1)) u_dut_wrap (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n),
        .key_plus(key_plus), .key_minus(key_minus), .key_clear(key_clear),
        .count(count_w), .plus_evt(pe_w), .minus_evt(me_w), .at_max(amax_w), .at_min(amin_w)
    );

    key_updown_counter #(.CNT_W(CW), .CNT_MAX(CMAX), .DEBOUNCE_CYC(DB),
                         .REPEAT_DLY_CYC(RDLY), .REPEAT_PER_CYC(RPER), .WRAP(0)) u_dut_sat (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n),
        .key_plus(key_plus), .key_minus(key_minus), .key_clear(key_clear),
        .count(count_s), .plus_evt(pe_s), .minus_evt(me_s), .at_max(amax_s), .at_min(amin_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state, per key: 0 plus, 1 minus, 2 clear.
    bit m_q1[3];
    bit m_q2[3];
    bit m_held[3];
    int m_run[3];
    int m_hold_n[3];
    bit m_evt[3];
    int m_cnt_w;
    int m_cnt_s;

    int obs_p, obs_m, obs_ps, obs_ms, first_p_cyc;
    int t0, p0, m0, ps0, ms0;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_q1[i]     = 1'b1;
            m_q2[i]     = 1'b1;
            m_held[i]   = 1'b0;
            m_run[i]    = 0;
            m_hold_n[i] = 0;
            m_evt[i]    = 1'b0;
        end
        m_cnt_w = 0;
        m_cnt_s = 0;
    endtask

    // One clock edge of the reference model, using the key levels present at that edge.
    task automatic model_edge();
        bit k[3];
        bit s;
        bit nevt;
        k[0] = key_plus;
        k[1] = key_minus;
        k[2] = key_clear;
        // Count reacts to the pulses of the cycle that this edge ends.
        if (m_evt[2]) begin
            m_cnt_w = 0;
            m_cnt_s = 0;
        end else if (m_evt[0] && !m_evt[1]) begin
            m_cnt_w = (m_cnt_w + 1) % (CMAX + 1);
            m_cnt_s = (m_cnt_s < CMAX) ? m_cnt_s + 1 : CMAX;
        end else if (m_evt[1] && !m_evt[0]) begin
            m_cnt_w = (m_cnt_w + CMAX) % (CMAX + 1);
            m_cnt_s = (m_cnt_s > 0) ? m_cnt_s - 1 : 0;
        end
        for (int i = 0; i < 3; i++) begin
            s       = m_q2[i];
            m_q2[i] = m_q1[i];
            m_q1[i] = k[i];
            nevt    = 1'b0;
            if (!m_held[i]) begin
                // Press accepted on the (DB+1)-th consecutive low sample.
                if (!s) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_held[i]   = 1'b1;
                        m_run[i]    = 0;
                        m_hold_n[i] = 0;
                        nevt        = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                if (s) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_held[i]   = 1'b0;
                        m_run[i]    = 0;
                        m_hold_n[i] = 0;
                    end
                end else begin
                    // Hold time only accrues while settled in the held state.
                    if (m_run[i] == 0 && i != 2) begin
                        m_hold_n[i]++;
                        if (m_hold_n[i] == RDLY ||
                            (m_hold_n[i] > RDLY && (m_hold_n[i] - RDLY) % RPER == 0))
                            nevt = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end
            m_evt[i] = nevt;
        end
    endtask

    task automatic compare_all();
        check("count_wrap",    int'(count_w), m_cnt_w);
        check("count_sat",     int'(count_s), m_cnt_s);
        check("plus_evt",      int'(pe_w),    int'(m_evt[0]));
        check("minus_evt",     int'(me_w),    int'(m_evt[1]));
        check("plus_evt_sat",  int'(pe_s),    int'(m_evt[0]));
        check("minus_evt_sat", int'(me_s),    int'(m_evt[1]));
        check("at_max_wrap",   int'(amax_w),  int'(m_cnt_w == CMAX));
        check("at_min_wrap",   int'(amin_w),  int'(m_cnt_w == 0));
        check("at_max_sat",    int'(amax_s),  int'(m_cnt_s == CMAX));
        check("at_min_sat",    int'(amin_s),  int'(m_cnt_s == 0));
        if (pe_w) obs_p++;
        if (me_w) obs_m++;
        if (pe_s) obs_ps++;
        if (me_s) obs_ms++;
        if (pe_w && first_p_cyc < 0) first_p_cyc = cyc;
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        cyc++;
        model_edge();
        @(negedge clk_50mhz);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Drive the selected keys low for 'low' cycles, then release and let the release filter settle.
    task automatic press(input bit p, input bit m, input bit c, input int low);
        key_plus  = !p;
        key_minus = !m;
        key_clear = !c;
        run(low);
        key_plus  = 1'b1;
        key_minus = 1'b1;
        key_clear = 1'b1;
        run(DB + 6);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count_wrap"}, int'(count_w), 0);
        check({tag, "_count_sat"},  int'(count_s), 0);
        check({tag, "_plus_evt"},   int'(pe_w),    0);
        check({tag, "_minus_evt"},  int'(me_w),    0);
        check({tag, "_at_min"},     int'(amin_w),  1);
        check({tag, "_at_max"},     int'(amax_w),  0);
        check({tag, "_at_min_sat"}, int'(amin_s),  1);
        check({tag, "_at_max_sat"}, int'(amax_s),  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        obs_p = 0; obs_m = 0; obs_ps = 0; obs_ms = 0;
        first_p_cyc = -1;
        repeat (3) @(negedge clk_50mhz);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        run(4);

        // Clean plus press: one pulse 10 cycles after first low sample, none on release.
        first_p_cyc = -1;
        t0 = cyc + 1;
        p0 = obs_p;
        key_plus = 1'b0;
        run(20);
        key_plus = 1'b1;
        run(20);
        check("clean_evts", obs_p - p0, 1);
        check("clean_latency", first_p_cyc - t0, DB + 2);
        check("clean_count", int'(count_w), 1);

        // Bouncing plus press: short glitches give nothing, the stable low gives one event.
        p0 = obs_p;
        for (int b = 0; b < 5; b++) begin
            key_plus = 1'b0;
            run($urandom_range(1, 7));
            key_plus = 1'b1;
            run($urandom_range(1, 7));
        end
        press(1'b1, 1'b0, 1'b0, 20);
        check("bounce_evts", obs_p - p0, 1);
        check("bounce_count", int'(count_w), 2);

        // Limits: minus at 0 wraps / holds, plus at max wraps / increments, minus back to max.
        press(1'b0, 1'b0, 1'b1, 20);
        check("clear_count", int'(count_w), 0);
        m0 = obs_m;
        ms0 = obs_ms;
        press(1'b0, 1'b1, 1'b0, 20);
        check("wrap_minus_count", int'(count_w), CMAX);
        check("wrap_minus_at_max", int'(amax_w), 1);
        check("sat_minus_count", int'(count_s), 0);
        check("sat_minus_evt", obs_ms - ms0, 1);
        check("wrap_minus_evt", obs_m - m0, 1);
        press(1'b1, 1'b0, 1'b0, 20);
        check("wrap_plus_count", int'(count_w), 0);
        check("wrap_plus_at_min", int'(amin_w), 1);
        check("sat_plus_count", int'(count_s), 1);
        press(1'b0, 1'b1, 1'b0, 20);
        check("wrap_minus2_count", int'(count_w), CMAX);
        check("wrap_minus2_at_max", int'(amax_w), 1);

        // Auto-repeat: held 60 cycles past the press event -> press plus four repeats.
        press(1'b0, 1'b0, 1'b1, 20);
        p0 = obs_p;
        press(1'b1, 1'b0, 1'b0, DB + 2 + 60);
        check("repeat_evts", obs_p - p0, 5);
        check("repeat_count", int'(count_w), 5);
        check("repeat_count_sat", int'(count_s), 5);

        // Plus and minus together: both pulse, count unchanged.
        p0 = obs_p;
        m0 = obs_m;
        press(1'b1, 1'b1, 1'b0, 20);
        check("both_plus_evt", obs_p - p0, 1);
        check("both_minus_evt", obs_m - m0, 1);
        check("both_count", int'(count_w), 5);

        // Clear together with plus: clear wins.
        p0 = obs_p;
        press(1'b1, 1'b0, 1'b1, 20);
        check("clear_plus_count", int'(count_w), 0);
        check("clear_plus_count_sat", int'(count_s), 0);
        check("clear_plus_evt", obs_p - p0, 1);

        // Reset mid-filter aborts the press; a key still held afterwards needs a full filter.
        press(1'b1, 1'b0, 1'b0, 20);
        p0 = obs_p;
        key_plus = 1'b0;
        run(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_no_evt", obs_p - p0, 0);
        model_reset();
        repeat (3) @(negedge clk_50mhz);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        first_p_cyc = -1;
        t0 = cyc + 1;
        p0 = obs_p;
        run(20);
        key_plus = 1'b1;
        run(20);
        check("post_reset_evts", obs_p - p0, 1);
        check("post_reset_latency", first_p_cyc - t0, DB + 2);
        check("post_reset_count", int'(count_w), 1);

        // Random key activity checked cycle by cycle against the model.
        for (int r = 0; r < 40; r++) begin
            key_plus  = ($urandom_range(0, 1) == 0);
            key_minus = ($urandom_range(0, 1) == 0);
            key_clear = ($urandom_range(0, 5) != 0);
            run($urandom_range(1, 60));
            key_plus  = 1'b1;
            key_minus = 1'b1;
            key_clear = 1'b1;
            run($urandom_range(1, 15));
        end
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
